// File: rtl/cpu_sequencer.sv
// cpu_sequencer: microstep counter and opcode/step decoder driving the 8-bit computer's control strobes.
module cpu_sequencer #(
    parameter int OPW      = 4,
    parameter int MAX_STEP = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic [7:0] instr,
    input  logic       flag_c,
    input  logic       flag_z,
    output logic [2:0] step,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       pc_oe,
    output logic       mar_load,
    output logic       ram_oe,
    output logic       ram_we,
    output logic       ir_load,
    output logic       ir_oe,
    output logic       a_load,
    output logic       a_oe,
    output logic       b_load,
    output logic       alu_oe,
    output logic       alu_sub,
    output logic       flags_load,
    output logic       out_load,
    output logic       halted,
    output logic [7:0] instr_count
);
    logic [OPW-1:0] op;
    logic [2:0]     step_q, step_d, last_raw, last_step;
    logic           halted_q, halted_d;
    logic [7:0]     instr_count_q, instr_count_d;
    logic           active, is_last, mem_op, jump;
    logic           t0, t1, t2, t3, t4;
    logic           is_lda, is_add, is_sub, is_sta, is_ldi, is_jmp, is_jc, is_jz, is_out, is_hlt;
    logic           unused_operand;

    assign op             = instr[7:8-OPW];
    assign unused_operand = ^instr[7-OPW:0];

    assign is_lda = op == OPW'(1);
    assign is_add = op == OPW'(2);
    assign is_sub = op == OPW'(3);
    assign is_sta = op == OPW'(4);
    assign is_ldi = op == OPW'(5);
    assign is_jmp = op == OPW'(6);
    assign is_jc  = op == OPW'(7);
    assign is_jz  = op == OPW'(8);
    assign is_out = op == OPW'(14);
    assign is_hlt = op == OPW'(15);

    assign last_raw  = (is_add | is_sub) ? 3'd4 : (is_lda | is_sta) ? 3'd3 : 3'd2;
    assign last_step = (last_raw > 3'(MAX_STEP)) ? 3'(MAX_STEP) : last_raw;
    assign is_last   = step_q >= last_step;

    assign active = run & ~halted_q & ~reset;
    assign t0     = active & (step_q == 3'd0);
    assign t1     = active & (step_q == 3'd1);
    assign t2     = active & (step_q == 3'd2);
    assign t3     = active & (step_q == 3'd3);
    assign t4     = active & (step_q == 3'd4);
    assign mem_op = is_lda | is_add | is_sub | is_sta;
    assign jump   = is_jmp | (is_jc & flag_c) | (is_jz & flag_z);

    always_comb begin
        step_d        = reset ? 3'd0 : active ? (is_last ? 3'd0 : step_q + 3'd1) : step_q;
        halted_d      = ~reset & (halted_q | (active & is_last & is_hlt));
        instr_count_d = reset ? 8'd0 : instr_count_q + {7'd0, active & is_last};
    end

    always_ff @(posedge clk) begin
        step_q        <= step_d;
        halted_q      <= halted_d;
        instr_count_q <= instr_count_d;
    end

    // Only one bus driver per step: fetch uses pc/ram, execute uses ir/ram/a/alu in disjoint steps.
    assign pc_oe      = t0;
    assign mar_load   = t0 | (t2 & mem_op);
    assign ram_oe     = t1 | (t3 & (is_lda | is_add | is_sub));
    assign ir_load    = t1;
    assign pc_inc     = t1;
    assign ir_oe      = t2 & (mem_op | is_ldi | jump);
    assign pc_load    = t2 & jump;
    assign a_load     = (t3 & is_lda) | (t2 & is_ldi) | (t4 & (is_add | is_sub));
    assign a_oe       = (t3 & is_sta) | (t2 & is_out);
    assign ram_we     = t3 & is_sta;
    assign b_load     = t3 & (is_add | is_sub);
    assign alu_oe     = t4 & (is_add | is_sub);
    assign alu_sub    = t4 & is_sub;
    assign flags_load = t4 & (is_add | is_sub);
    assign out_load   = t2 & is_out;

    assign step        = step_q;
    assign halted      = halted_q;
    assign instr_count = instr_count_q;
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed and random checks of cpu_sequencer against a microprogram-table model.
module tb_cpu_sequencer;
    logic       clk = 0, reset = 1, run = 0, flag_c = 0, flag_z = 0;
    logic [7:0] instr = 8'h00;
    logic [2:0] step;
    logic       pc_inc, pc_load, pc_oe, mar_load, ram_oe, ram_we, ir_load, ir_oe;
    logic       a_load, a_oe, b_load, alu_oe, alu_sub, flags_load, out_load, halted;
    logic [7:0] instr_count;

    int  vectors = 0, errors = 0;
    int  m_step = 0, m_cnt = 0;
    bit  m_halt = 0, running = 1;

    localparam logic [14:0] PC_INC = 15'h4000, PC_LOAD = 15'h2000, PC_OE = 15'h1000, MAR_LOAD = 15'h0800;
    localparam logic [14:0] RAM_OE = 15'h0400, RAM_WE = 15'h0200, IR_LOAD = 15'h0100, IR_OE = 15'h0080;
    localparam logic [14:0] A_LOAD = 15'h0040, A_OE = 15'h0020, B_LOAD = 15'h0010, ALU_OE = 15'h0008;
    localparam logic [14:0] ALU_SUB = 15'h0004, FLAGS_LOAD = 15'h0002, OUT_LOAD = 15'h0001;

    cpu_sequencer dut (
        .clk(clk), .reset(reset), .run(run), .instr(instr), .flag_c(flag_c), .flag_z(flag_z),
        .step(step), .pc_inc(pc_inc), .pc_load(pc_load), .pc_oe(pc_oe), .mar_load(mar_load),
        .ram_oe(ram_oe), .ram_we(ram_we), .ir_load(ir_load), .ir_oe(ir_oe), .a_load(a_load),
        .a_oe(a_oe), .b_load(b_load), .alu_oe(alu_oe), .alu_sub(alu_sub), .flags_load(flags_load),
        .out_load(out_load), .halted(halted), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    wire [14:0] strobes = {pc_inc, pc_load, pc_oe, mar_load, ram_oe, ram_we, ir_load, ir_oe,
                           a_load, a_oe, b_load, alu_oe, alu_sub, flags_load, out_load};
    wire [26:0] obs = {step, halted, instr_count, strobes};

    function automatic int cycles_of(input int op);
        return (op == 2 || op == 3) ? 5 : (op == 1 || op == 4) ? 4 : 3;
    endfunction

    function automatic logic [14:0] exp_strobes();
        int op;
        op = int'(instr[7:4]);
        if (reset || !run || m_halt) return 15'd0;
        if (m_step == 0) return PC_OE | MAR_LOAD;
        if (m_step == 1) return RAM_OE | IR_LOAD | PC_INC;
        case (op)
            1:       return m_step == 2 ? IR_OE | MAR_LOAD : RAM_OE | A_LOAD;
            2, 3:    return m_step == 2 ? IR_OE | MAR_LOAD : m_step == 3 ? RAM_OE | B_LOAD :
                            ALU_OE | A_LOAD | FLAGS_LOAD | (op == 3 ? ALU_SUB : 15'd0);
            4:       return m_step == 2 ? IR_OE | MAR_LOAD : A_OE | RAM_WE;
            5:       return IR_OE | A_LOAD;
            6:       return IR_OE | PC_LOAD;
            7:       return flag_c ? IR_OE | PC_LOAD : 15'd0;
            8:       return flag_z ? IR_OE | PC_LOAD : 15'd0;
            14:      return A_OE | OUT_LOAD;
            default: return 15'd0;
        endcase
    endfunction

    function automatic logic [26:0] exp_vec();
        return {3'(m_step), m_halt, 8'(m_cnt), exp_strobes()};
    endfunction

    task automatic adv();
        @(posedge clk);
        if (reset) begin
            m_step = 0; m_halt = 0; m_cnt = 0;
        end else if (run && !m_halt) begin
            if (m_step == cycles_of(int'(instr[7:4])) - 1) begin
                m_step = 0;
                m_cnt  = (m_cnt + 1) % 256;
                if (instr[7:4] == 4'hF) m_halt = 1;
            end else m_step++;
        end
        #1;
    endtask

    always @(negedge clk) if (running && !reset) begin
        vectors++;
        if ($countones({pc_oe, ram_oe, ir_oe, a_oe, alu_oe}) > 1) begin
            errors++;
            $display("FAIL bus_excl: drivers=%b required at most one", {pc_oe, ram_oe, ir_oe, a_oe, alu_oe});
        end
    end

    task automatic test_reset();
        reset = 1; run = 0; instr = 8'h00;
        adv();
        run = 1;
        #2; vectors++;
        if (obs !== exp_vec()) begin errors++; $display("FAIL reset: got %h want %h", obs, exp_vec()); end
        reset = 0;
    endtask

    task automatic test_nop();
        run = 1; instr = 8'h00;
        repeat (6) begin
            #2; vectors++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL nop: got %h want %h", obs, exp_vec()); end
            adv();
        end
        vectors++;
        if (instr_count !== 8'd2) begin errors++; $display("FAIL nop_count: got %0d want 2", instr_count); end
    endtask

    task automatic test_add_sub();
        for (int op = 2; op <= 3; op++) begin
            instr = {4'(op), 4'($urandom_range(0, 15))};
            repeat (5) begin
                #2; vectors++;
                if (obs !== exp_vec()) begin errors++; $display("FAIL add_sub op%0d: got %h want %h", op, obs, exp_vec()); end
                adv();
            end
        end
    endtask

    task automatic test_cond_jump();
        for (int op = 7; op <= 8; op++)
            for (int f = 0; f <= 1; f++) begin
                instr = {4'(op), 4'd3}; flag_c = (op == 7) ? 1'(f) : 1'(~f); flag_z = (op == 8) ? 1'(f) : 1'(~f);
                repeat (3) begin
                    #2; vectors++;
                    if (obs !== exp_vec()) begin errors++; $display("FAIL jump op%0d f%0d: got %h want %h", op, f, obs, exp_vec()); end
                    adv();
                end
            end
    endtask

    task automatic test_stall();
        instr = 8'h1A; run = 1;
        for (int c = 0; c < 9; c++) begin
            run = !(c >= 3 && c < 7);
            #2; vectors++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL stall c%0d: got %h want %h", c, obs, exp_vec()); end
            adv();
        end
    endtask

    task automatic test_halt();
        instr = 8'hF0; run = 1;
        for (int c = 0; c < 23; c++) begin
            if (c >= 3) begin
                run = 1'($urandom_range(0, 1)); instr = 8'($urandom); flag_c = 1'($urandom); flag_z = 1'($urandom);
            end
            #2; vectors++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL halt c%0d: got %h want %h", c, obs, exp_vec()); end
            adv();
        end
        reset = 1;
        adv();
        reset = 0; run = 1; instr = 8'h00;
        #2; vectors++;
        if (obs !== exp_vec()) begin errors++; $display("FAIL halt_reset: got %h want %h", obs, exp_vec()); end
        adv();
    endtask

    task automatic test_wrap();
        reset = 1;
        adv();
        reset = 0; run = 1; instr = 8'h00;
        repeat (768) begin
            #2; vectors++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL wrap: got %h want %h", obs, exp_vec()); end
            adv();
        end
        vectors++;
        if (instr_count !== 8'h00) begin errors++; $display("FAIL wrap_count: got %h want 00", instr_count); end
        adv();
        reset = 1;
        for (int c = 0; c < 3; c++) begin
            #2; vectors++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL mid_reset c%0d: got %h want %h", c, obs, exp_vec()); end
            adv();
            reset = 0;
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            if (m_step < 2) instr = {4'($urandom_range(0, 14)), 4'($urandom)};
            run = $urandom_range(0, 3) != 0; flag_c = 1'($urandom); flag_z = 1'($urandom);
            reset = $urandom_range(0, 49) == 0;
            #2; vectors++;
            if (obs !== exp_vec()) begin errors++; $display("FAIL random c%0d: got %h want %h", c, obs, exp_vec()); end
            adv();
        end
        reset = 0;
    endtask

    initial begin
        test_reset();
        test_nop();
        test_add_sub();
        test_cond_jump();
        test_stall();
        test_halt();
        test_wrap();
        test_random();
        running = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
